// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready producers into one registered output stage,
// with multi-beat grant locking and flush. Define RR_ARB_PERF_EN to add a stall-cycle counter.
module rr_stage_arbiter #(
    parameter int unsigned  N_REQ = 4,
    parameter int unsigned  WIDTH = 32,
    localparam int unsigned SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       prv_valid,
    input  logic [N_REQ-1:0]       prv_lock,
    output logic [N_REQ-1:0]       prv_ready,
    input  logic [N_REQ*WIDTH-1:0] prv_data,
    output logic                   nxt_valid,
    input  logic                   nxt_ready,
    output logic [WIDTH-1:0]       nxt_data,
    output logic [SRC_W-1:0]       nxt_src,
    output logic                   locked
`ifdef RR_ARB_PERF_EN
    ,
    output logic [15:0]            perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0] src_q, src_d;

    logic             accept;
    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;

    // Modulo-N_REQ add so non-power-of-two sizes wrap at N_REQ, not 2^SRC_W.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return SRC_W'(s);
    endfunction

    assign accept = !rst && !flush && (!valid_q || nxt_ready);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (state_q == StLocked) begin
            win_found = prv_valid[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!win_found && prv_valid[wrap_add(ptr_q, k)]) begin
                    win_found = 1'b1;
                    win_idx   = wrap_add(ptr_q, k);
                end
            end
        end
    end

    assign win_data = prv_data[32'(win_idx)*WIDTH +: WIDTH];

    always_comb begin
        prv_ready = '0;
        if (accept && win_found) prv_ready[win_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = StIdle;
        end else if (accept) begin
            valid_d = win_found;
            if (win_found) begin
                data_d = win_data;
                src_d  = win_idx;
                if (prv_lock[win_idx]) begin
                    state_d = StLocked;
                    owner_d = win_idx;
                end else begin
                    state_d = StIdle;
                    ptr_d   = wrap_add(win_idx, 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign nxt_valid = valid_q;
    assign nxt_data  = data_q;
    assign nxt_src   = src_q;
    assign locked    = (state_q == StLocked);

`ifdef RR_ARB_PERF_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where the held entry is blocked downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !nxt_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/rr_stage_arbiter.md
# rr_stage_arbiter

- Round-robin arbiter merging `N_REQ` valid/ready producers into one registered pipeline stage.
- Placement: in front of a shared resource such as a functional-unit issue port or CDB slot.
- Selects one requester per cycle and captures its payload into a one-entry output register, with 1-cycle latency and full throughput.
- Supports multi-beat grant locking and pipeline flush.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 32, payload width per requester
- `SRC_W`, `$clog2(N_REQ)`, width of source index (derived, localparam)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  drop held entry and release lock
- `prv_valid`  in  N_REQ  per-requester valid
- `prv_lock`  in  N_REQ  per-requester "keep grant after this beat"
- `prv_ready`  out  N_REQ  per-requester ready; one-hot or zero
- `prv_data`  in  N_REQ*WIDTH  payloads; requester i at bits [i*WIDTH +: WIDTH]
- `nxt_valid`  out  1  output entry valid
- `nxt_ready`  in  1  downstream ready
- `nxt_data`  out  WIDTH  held payload
- `nxt_src`  out  SRC_W  index of requester that produced `nxt_data`
- `locked`  out  1  lock state active

## Operation
State:
- Round-robin pointer `ptr` (SRC_W bits).
- Lock FSM with two states: IDLE and LOCKED(`owner`).
- Output register holding `nxt_valid`, `nxt_data`, `nxt_src`.

Accept and grant:
- `accept = !flush && (!nxt_valid || nxt_ready)`.
- In IDLE, the winner is the first i with `prv_valid[i]`, scanning `ptr, ptr+1, …` modulo N_REQ.
- In LOCKED, the winner is `owner` only if `prv_valid[owner]`; otherwise there is no winner and all other requesters stall.
- `prv_ready[i] = accept && winner_exists && winner==i`.
- `prv_ready` depends combinationally on `prv_valid` and `nxt_ready`. Requesters must not derive `prv_valid` from `prv_ready`.

On a transfer by requester w:
- Output register loads `prv_data[w]` and `nxt_src <= w`.
- `prv_lock[w]=1`: state becomes LOCKED with `owner=w`; `ptr` is unchanged.
- `prv_lock[w]=0`: state becomes IDLE and `ptr <= (w+1) mod N_REQ`. This applies equally to release from LOCKED.

Output register:
- Accept with no winner: `nxt_valid <= 0`.
- No accept: register holds. `nxt_data` and `nxt_src` stay stable while `nxt_valid && !nxt_ready`.

Flush:
- Sets `nxt_valid <= 0` and state to IDLE.
- `ptr` is unchanged; `nxt_data` and `nxt_src` hold.
- `prv_ready` is all-zero during flush, so no upstream beat is lost.

`locked` output: 1 iff state is LOCKED.

## Timing
- Reset values: `nxt_valid=0`, `nxt_data=0`, `nxt_src=0`, `locked=0`, `ptr=0`, state IDLE. `prv_ready` is 0 during the reset cycle.
- Latency: a beat accepted at edge k shows `nxt_valid=1` after edge k.
- Throughput: one beat per cycle when `nxt_ready` is held high.
- Simultaneous downstream pop and upstream push in one cycle: allowed. The register is overwritten and `nxt_valid` stays 1.
- `flush` together with `rst`: reset behaviour applies.
- `flush` while LOCKED: the lock is released. The owner must re-arbitrate.
- Empty inputs: `nxt_valid` falls after the last popped beat. `ptr` does not move without a transfer.
- Wrap-around: a transfer from requester N_REQ-1 with no lock sets `ptr=0`.
- Non-power-of-two N_REQ: the pointer wraps at N_REQ, not at 2^SRC_W.

## Configuration
Macro `RR_ARB_PERF_EN`.
- Defined:
  - Adds port `perf_stall_cnt` (out, 16 bits).
  - Counts cycles with `nxt_valid && !nxt_ready`, saturating at 0xFFFF.
  - Cleared by `rst` only; unaffected by `flush`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset then fairness.** After reset, all four requesters are valid with data 0xA0..0xA3 and `nxt_ready=1`. Required: outputs appear in order src 0,1,2,3,0 on consecutive cycles; first `nxt_valid` one cycle after first accept.
- **Backpressure.** With `nxt_ready=0` for 3 cycles, `nxt_data`/`nxt_src` stay stable and every `prv_ready` stays 0. On release, the held beat pops and the next winner is accepted in the same cycle.
- **Lock.**
  - Stimulus: req1 sends 3 beats with lock=1,1,0 while req0/req2 are valid.
  - Required: src sequence 1,1,1 and then 2. `locked` is high from after beat 1 through beat 3, and req0/req2 `prv_ready` stay 0 meanwhile.
  - Also required: a cycle with the owner invalid while LOCKED produces no transfer.
- **Flush.** Flush in the same cycle as a pending accept with `nxt_valid=1` and LOCKED. Required: all `prv_ready` are 0, then `nxt_valid=0` and `locked=0` next cycle, and `ptr` is unchanged.
- **Wrap, N_REQ=3.** Only req2 then req0 valid. Required: pointer wraps 2→0; req0 is granted next without gaps.
- **Perf (`RR_ARB_PERF_EN`).** Stall 5 cycles, then flush. Required: `perf_stall_cnt=5` after the stall and still 5 after the flush.
